// File: rtl/fault_mem_pkg.sv
// fault_mem_pkg: shared definitions for the fault-injecting memory responder.
//   AW_DEF / DW_DEF / NFAULT_DEF : default address width, data width and
//                                  number of fault table entries
//   state_t                      : INIT (post-reset clear sweep) / RUN
//   fault_entry_t                : one fault table entry {en, addr, sa0, sa1}
//   sat_inc                      : saturating increment for the statistics counters
package fault_mem_pkg;

  localparam int AW_DEF     = 8;
  localparam int DW_DEF     = 8;
  localparam int NFAULT_DEF = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Field widths follow the package defaults; the modules are instantiated
  // with matching AW/DW.
  typedef struct packed {
    logic              en;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] sa0;
    logic [DW_DEF-1:0] sa1;
  } fault_entry_t;

  // Increment v by one, stopping at max_v. Callers cast to their counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fault_mem_ftab.sv
// fault_mem_ftab: NFAULT-entry stuck-at fault table.
//   clock, reset         : clock / synchronous active-high reset (clears all entries)
//   wr_en, wr_idx        : write one entry (wr_idx outside the table is ignored)
//   wr_entry_en, wr_addr,
//   wr_sa0, wr_sa1       : contents of the entry being written
//   addr, raw            : lookup address and the raw stored word
//   faulted              : raw word with all matching enabled entries applied
//   hit                  : faulted differs from raw
module fault_mem_ftab
  import fault_mem_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int NFAULT = NFAULT_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(NFAULT)-1:0] wr_idx,
  input  logic                      wr_entry_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DW-1:0]             wr_sa0,
  input  logic [DW-1:0]             wr_sa1,
  input  logic [AW-1:0]             addr,
  input  logic [DW-1:0]             raw,
  output logic [DW-1:0]             faulted,
  output logic                      hit
);

  fault_entry_t table_reg [NFAULT];
  fault_entry_t entry_next;

  always_comb begin
    entry_next      = '0;
    entry_next.en   = wr_entry_en;
    entry_next.addr = wr_addr;
    entry_next.sa0  = wr_sa0;
    entry_next.sa1  = wr_sa1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NFAULT; i++) begin
        table_reg[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NFAULT; i++) begin
        if (int'(wr_idx) == i) begin
          table_reg[i] <= entry_next;
        end
      end
    end
  end

  // Entries are applied in ascending index order, so a later entry on the
  // same address sees the output of the earlier ones. Within one entry sa1
  // is OR-ed last, so a bit set in both masks ends up 1.
  always_comb begin
    faulted = raw;
    for (int i = 0; i < NFAULT; i++) begin
      if (table_reg[i].en && (table_reg[i].addr == addr)) begin
        faulted = (faulted & ~table_reg[i].sa0) | table_reg[i].sa1;
      end
    end
  end

  assign hit = (faulted != raw);

endmodule

// File: rtl/fault_mem.sv
// fault_mem: responder side of the memory tester interface. A 2**AW x DW
// synchronous RAM with programmable stuck-at faults on the read path.
// After reset the whole array is swept to zero (busy high), then every
// cycle is a read (registered, 1-cycle latency, read-before-write).
//   clock, reset              : rising-edge clock / synchronous active-high reset
//   we, wra, wrd              : tester write port (ignored while busy)
//   rda, rdd                  : tester read address / registered faulted data
//   busy                      : clear sweep in progress
//   cfg_valid, cfg_ready      : fault table config handshake (one bubble after
//                               each accepted transfer)
//   cfg_idx, cfg_en, cfg_addr,
//   cfg_sa0, cfg_sa1          : fault table entry being configured
//   wr_count, rd_count,
//   fault_hits                : saturating statistics counters
// Optional build macro MEM_PARITY_EN adds a stored even-parity bit per word
// and the outputs parity_err (one-cycle pulse aligned with rdd) and
// parity_errs (saturating count).
module fault_mem
  import fault_mem_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int NFAULT = NFAULT_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      we,
  input  logic [AW-1:0]             wra,
  input  logic [DW-1:0]             wrd,
  input  logic [AW-1:0]             rda,
  output logic [DW-1:0]             rdd,
  output logic                      busy,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NFAULT)-1:0] cfg_idx,
  input  logic                      cfg_en,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [DW-1:0]             cfg_sa0,
  input  logic [DW-1:0]             cfg_sa1,
  output logic [AW:0]               wr_count,
  output logic [AW:0]               rd_count,
  output logic [AW:0]               fault_hits
`ifdef MEM_PARITY_EN
  ,
  output logic                      parity_err,
  output logic [AW:0]               parity_errs
`endif
);

  localparam logic [31:0] CNT_MAX = (32'd1 << (AW + 1)) - 32'd1;

`ifdef MEM_PARITY_EN
  localparam int MW = DW + 1;   // parity bit kept in the MSB
`else
  localparam int MW = DW;
`endif

  state_t        state_reg, state_next;
  logic [AW-1:0] ptr_reg, ptr_next;
  logic          bubble_reg;
  logic          running;
  logic          cfg_fire;

  logic [MW-1:0] mem [2**AW];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [MW-1:0] mem_wd;
  logic [MW-1:0] rd_word;
  logic [DW-1:0] raw_word;
  logic [DW-1:0] faulted_word;
  logic          fault_hit;

  assign running   = (state_reg == RUN);
  assign busy      = ~running;
  assign cfg_ready = running & ~bubble_reg;
  assign cfg_fire  = cfg_valid & cfg_ready;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= INIT;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // FSM: next state. The sweep leaves INIT right after the last word is cleared.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      INIT: begin
        ptr_next = ptr_reg + 1'b1;
        if (ptr_reg == '1) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: state_next = INIT;
    endcase
  end

  // Single write port shared between the clear sweep and the tester.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = ptr_reg;
    mem_wd = '0;
    if (!reset) begin
      if (running) begin
        mem_we = we;
        mem_wa = wra;
`ifdef MEM_PARITY_EN
        mem_wd = {^wrd, wrd};
`else
        mem_wd = wrd;
`endif
      end else begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Read before write: the array read sees the contents prior to this edge.
  assign rd_word  = mem[rda];
  assign raw_word = rd_word[DW-1:0];

  fault_mem_ftab #(
    .AW     (AW),
    .DW     (DW),
    .NFAULT (NFAULT)
  ) u_ftab (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (cfg_fire),
    .wr_idx      (cfg_idx),
    .wr_entry_en (cfg_en),
    .wr_addr     (cfg_addr),
    .wr_sa0      (cfg_sa0),
    .wr_sa1      (cfg_sa1),
    .addr        (rda),
    .raw         (raw_word),
    .faulted     (faulted_word),
    .hit         (fault_hit)
  );

  // Registered read data, handshake bubble and statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdd        <= '0;
      bubble_reg <= 1'b0;
      wr_count   <= '0;
      rd_count   <= '0;
      fault_hits <= '0;
    end else if (running) begin
      rdd        <= faulted_word;
      bubble_reg <= cfg_fire;
      rd_count   <= (AW+1)'(sat_inc(32'(rd_count), CNT_MAX));
      if (we) begin
        wr_count <= (AW+1)'(sat_inc(32'(wr_count), CNT_MAX));
      end
      if (fault_hit) begin
        fault_hits <= (AW+1)'(sat_inc(32'(fault_hits), CNT_MAX));
      end
    end else begin
      rdd        <= '0;
      bubble_reg <= 1'b0;
    end
  end

`ifdef MEM_PARITY_EN
  logic parity_bad;

  // Parity is stored from the raw write data, so any fault that flips an
  // odd number of bits shows up here.
  assign parity_bad = (^faulted_word) != rd_word[DW];

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_err  <= 1'b0;
      parity_errs <= '0;
    end else if (running) begin
      parity_err <= parity_bad;
      if (parity_bad) begin
        parity_errs <= (AW+1)'(sat_inc(32'(parity_errs), CNT_MAX));
      end
    end else begin
      parity_err <= 1'b0;
    end
  end
`endif

endmodule
